// File: rtl/writeback_beats.sv
// -----------------------------------------------------------------------------
// writeback_beats
//
// Multi-beat result writer. Accepts one wide result (BEATS x DATA_W bits) per
// in_valid/in_ready handshake and emits it toward the result memory as BEATS
// consecutive DATA_W-bit beats at addresses base, base+stride, base+2*stride...
// (ADDR_W-bit wrap-around). A one-entry pending slot lets the next result be
// accepted while the current one is still being written, so back-to-back
// results stream with no idle cycle between them.
//
// Ports
//   CLK, RESETn          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    result handshake; in_ready depends on registered
//                        state only (pending slot empty)
//   in_q                 result, beat k = in_q[k*DATA_W +: DATA_W]
//   in_base, in_stride   address of beat 0, address increment per beat
//   wr_en/wr_ready       beat handshake toward memory; a beat transfers on
//                        wr_en && wr_ready, otherwise wr_* hold stable
//   wr_addr, wr_data     beat address and data (registered)
//   busy                 a beat is being offered or a result is pending
//   done_pulse           one-cycle pulse after each result's final beat
//   done_count           number of completed results, wraps
// -----------------------------------------------------------------------------
module writeback_beats #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int BEATS  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BEATS*DATA_W-1:0] in_q,
    input  logic [ADDR_W-1:0]       in_base,
    input  logic [ADDR_W-1:0]       in_stride,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [CNT_W-1:0]        done_count
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Active slot. The result is held as a shift register: the current beat
    // always sits in the low DATA_W bits, so wr_data is a plain register slice.
    logic [BEATS*DATA_W-1:0] act_beats_reg;
    logic [BEATS*DATA_W-1:0] act_beats_shifted;
    logic [ADDR_W-1:0]       act_stride_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [IDX_W-1:0]        beat_idx_reg;

    // Pending slot
    logic                    pend_valid_reg;
    logic [BEATS*DATA_W-1:0] pend_q_reg;
    logic [ADDR_W-1:0]       pend_base_reg;
    logic [ADDR_W-1:0]       pend_stride_reg;

    logic                    done_pulse_reg;
    logic [CNT_W-1:0]        done_count_reg;

    // Control decode
    logic accept;
    logic xfer;
    logic last_beat;
    logic load_from_pend;
    logic load_from_in;
    logic push_pend;

    generate
        if (BEATS > 1) begin : g_shift
            assign act_beats_shifted = {{DATA_W{1'b0}}, act_beats_reg[BEATS*DATA_W-1:DATA_W]};
        end else begin : g_noshift
            assign act_beats_shifted = '0;
        end
    endgenerate

    always_comb begin
        accept         = in_valid && !pend_valid_reg;
        xfer           = (state_reg == ST_WRITE) && wr_ready;
        last_beat      = xfer && (beat_idx_reg == LAST_IDX);
        // A pending result always has priority when the active one finishes;
        // in that cycle in_ready is low so no input can compete with it.
        load_from_pend = last_beat && pend_valid_reg;
        // accept already implies the pending slot is empty.
        load_from_in   = accept && ((state_reg == ST_IDLE) || last_beat);
        push_pend      = accept && (state_reg == ST_WRITE) && !last_beat;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_beat && !load_from_pend && !load_from_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_en    = (state_reg == ST_WRITE);
        busy     = (state_reg == ST_WRITE) || pend_valid_reg;
        in_ready = !pend_valid_reg;
    end

    // ---------------- Active slot datapath ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            act_beats_reg  <= '0;
            act_stride_reg <= '0;
            addr_reg       <= '0;
            beat_idx_reg   <= '0;
        end else if (load_from_pend) begin
            act_beats_reg  <= pend_q_reg;
            act_stride_reg <= pend_stride_reg;
            addr_reg       <= pend_base_reg;
            beat_idx_reg   <= '0;
        end else if (load_from_in) begin
            act_beats_reg  <= in_q;
            act_stride_reg <= in_stride;
            addr_reg       <= in_base;
            beat_idx_reg   <= '0;
        end else if (xfer && !last_beat) begin
            act_beats_reg  <= act_beats_shifted;
            addr_reg       <= addr_reg + act_stride_reg;
            beat_idx_reg   <= beat_idx_reg + IDX_W'(1);
        end
    end

    // ---------------- Pending slot ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pend_valid_reg  <= 1'b0;
            pend_q_reg      <= '0;
            pend_base_reg   <= '0;
            pend_stride_reg <= '0;
        end else if (push_pend) begin
            pend_valid_reg  <= 1'b1;
            pend_q_reg      <= in_q;
            pend_base_reg   <= in_base;
            pend_stride_reg <= in_stride;
        end else if (load_from_pend) begin
            pend_valid_reg  <= 1'b0;
        end
    end

    // ---------------- Completion tracking ----------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            done_pulse_reg <= 1'b0;
            done_count_reg <= '0;
        end else begin
            done_pulse_reg <= last_beat;
            if (last_beat) begin
                done_count_reg <= done_count_reg + CNT_W'(1);
            end
        end
    end

    assign wr_addr    = addr_reg;
    assign wr_data    = act_beats_reg[DATA_W-1:0];
    assign done_pulse = done_pulse_reg;
    assign done_count = done_count_reg;

endmodule

// File: tb/tb_writeback_beats.sv
// -----------------------------------------------------------------------------
// tb_writeback_beats
//
// Two instances share clock and reset: instance 0 uses the default geometry
// (2 x 128-bit beats, 16-bit count), instance 1 uses 4 x 32-bit beats with a
// 2-bit count. A queue-style reference model (at most two results in flight:
// the one being written plus one waiting) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_writeback_beats;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    // Drive side, index 0 = default instance, 1 = 4x32 instance
    logic         drv_valid    [2];
    logic [255:0] drv_q        [2];
    logic [15:0]  drv_base     [2];
    logic [15:0]  drv_stride   [2];
    logic         drv_wr_ready [2];

    logic         in_ready_a, wr_en_a, busy_a, done_pulse_a;
    logic [15:0]  wr_addr_a, done_count_a;
    logic [127:0] wr_data_a;
    logic         in_ready_b, wr_en_b, busy_b, done_pulse_b;
    logic [15:0]  wr_addr_b;
    logic [31:0]  wr_data_b;
    logic [1:0]   done_count_b;

    writeback_beats dut_a (
        .CLK(CLK), .RESETn(RESETn),
        .in_valid(drv_valid[0]), .in_ready(in_ready_a),
        .in_q(drv_q[0]), .in_base(drv_base[0]), .in_stride(drv_stride[0]),
        .wr_en(wr_en_a), .wr_ready(drv_wr_ready[0]),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done_pulse(done_pulse_a), .done_count(done_count_a)
    );

    writeback_beats #(.ADDR_W(16), .DATA_W(32), .BEATS(4), .CNT_W(2)) dut_b (
        .CLK(CLK), .RESETn(RESETn),
        .in_valid(drv_valid[1]), .in_ready(in_ready_b),
        .in_q(drv_q[1][127:0]), .in_base(drv_base[1]), .in_stride(drv_stride[1]),
        .wr_en(wr_en_b), .wr_ready(drv_wr_ready[1]),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done_pulse(done_pulse_b), .done_count(done_count_b)
    );

    // Observed outputs gathered into arrays
    logic         obs_rdy [2], obs_en [2], obs_busy [2], obs_done [2];
    logic [15:0]  obs_addr [2], obs_cnt [2];
    logic [127:0] obs_data [2];
    assign obs_rdy[0]  = in_ready_a;   assign obs_rdy[1]  = in_ready_b;
    assign obs_en[0]   = wr_en_a;      assign obs_en[1]   = wr_en_b;
    assign obs_busy[0] = busy_a;       assign obs_busy[1] = busy_b;
    assign obs_done[0] = done_pulse_a; assign obs_done[1] = done_pulse_b;
    assign obs_addr[0] = wr_addr_a;    assign obs_addr[1] = wr_addr_b;
    assign obs_cnt[0]  = done_count_a; assign obs_cnt[1]  = {14'b0, done_count_b};
    assign obs_data[0] = wr_data_a;    assign obs_data[1] = {96'b0, wr_data_b};

    function automatic int dw(input int i); return (i == 0) ? 128 : 32; endfunction
    function automatic int bt(input int i); return (i == 0) ? 2 : 4;    endfunction
    function automatic int cw(input int i); return (i == 0) ? 16 : 2;   endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int i, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    // Slot 0 is the result being written (beat m_k), slot 1 the waiting one.
    int           m_n   [2] = '{0, 0};
    int           m_k   [2] = '{0, 0};
    int           m_cnt [2] = '{0, 0};
    bit           m_done[2] = '{0, 0};
    logic [255:0] m_q     [2][2];
    logic [15:0]  m_base  [2][2];
    logic [15:0]  m_stride[2][2];

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < 2; i++) begin
                m_n[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit rdy;
                rdy = (m_n[i] < 2);
                m_done[i] = 0;
                if (m_n[i] > 0 && drv_wr_ready[i]) begin
                    m_k[i]++;
                    if (m_k[i] == bt(i)) begin
                        m_k[i] = 0;
                        m_q[i][0] = m_q[i][1];
                        m_base[i][0] = m_base[i][1];
                        m_stride[i][0] = m_stride[i][1];
                        m_n[i]--;
                        m_done[i] = 1;
                        m_cnt[i] = (m_cnt[i] + 1) % (1 << cw(i));
                    end
                end
                if (drv_valid[i] && rdy) begin
                    m_q[i][m_n[i]] = drv_q[i];
                    m_base[i][m_n[i]] = drv_base[i];
                    m_stride[i][m_n[i]] = drv_stride[i];
                    m_n[i]++;
                end
            end
        end
    end

    // ---------------- Compare process ----------------
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [255:0] mask;
            logic [15:0]  ea;
            mask = (256'(1) << dw(i)) - 256'(1);
            chk("in_ready",   i, 256'(obs_rdy[i]),  256'(m_n[i] < 2));
            chk("wr_en",      i, 256'(obs_en[i]),   256'(m_n[i] > 0));
            chk("busy",       i, 256'(obs_busy[i]), 256'(m_n[i] > 0));
            chk("done_pulse", i, 256'(obs_done[i]), 256'(m_done[i]));
            chk("done_count", i, 256'(obs_cnt[i]),  256'(m_cnt[i]));
            if (m_n[i] > 0) begin
                ea = 16'(m_base[i][0] + 16'(m_k[i]) * m_stride[i][0]);
                chk("wr_addr", i, 256'(obs_addr[i]), 256'(ea));
                chk("wr_data", i, 256'(obs_data[i]), (m_q[i][0] >> (m_k[i] * dw(i))) & mask);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    // Present a result and hold it until accepted; returns one cycle after the
    // accepting edge, with in_valid still high.
    task automatic send(input int i, input logic [255:0] q, input logic [15:0] base, input logic [15:0] stride);
        bit ok;
        drv_valid[i] = 1'b1; drv_q[i] = q; drv_base[i] = base; drv_stride[i] = stride;
        for (int n = 0; n < 200; n++) begin
            ok = (i == 0) ? in_ready_a : in_ready_b;
            cyc();
            if (ok) return;
        end
        n_vec++; n_err++;
        $display("FAIL accept_timeout[%0d] got no in_ready required in_ready within 200 cycles", i);
    endtask

    task automatic idle(input int i);
        drv_valid[i] = 1'b0;
    endtask

    localparam logic [127:0] BEAT_A = {4{32'hAAAA_0001}};
    localparam logic [127:0] BEAT_B = {4{32'hBBBB_0002}};
    logic [15:0] exp_addr_b [4] = '{16'hFFFE, 16'h0001, 16'h0004, 16'h0007};
    logic [31:0] beat_b     [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [1:0]  wrap_seq   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        logic [255:0] qb;
        for (int i = 0; i < 2; i++) begin
            drv_valid[i] = 0; drv_q[i] = '0; drv_base[i] = '0; drv_stride[i] = '0; drv_wr_ready[i] = 1;
        end
        repeat (3) cyc();
        chk("lit_rst_in_ready", 0, 256'(in_ready_a), 256'(1));
        chk("lit_rst_wr_en",    0, 256'(wr_en_a),    256'(0));
        chk("lit_rst_count",    0, 256'(done_count_a), 256'(0));
        RESETn = 1'b1;
        cyc();

        // Single result, two beats
        send(0, {BEAT_B, BEAT_A}, 16'h0010, 16'h0001);
        idle(0);
        chk("lit_s1_en0",   0, 256'(wr_en_a),   256'(1));
        chk("lit_s1_addr0", 0, 256'(wr_addr_a), 256'(16'h0010));
        chk("lit_s1_data0", 0, 256'(wr_data_a), 256'(BEAT_A));
        cyc();
        chk("lit_s1_addr1", 0, 256'(wr_addr_a), 256'(16'h0011));
        chk("lit_s1_data1", 0, 256'(wr_data_a), 256'(BEAT_B));
        cyc();
        chk("lit_s1_done",  0, 256'(done_pulse_a), 256'(1));
        chk("lit_s1_count", 0, 256'(done_count_a), 256'(1));
        chk("lit_s1_idle",  0, 256'(wr_en_a),      256'(0));

        // Back-to-back: three results offered continuously
        send(0, {BEAT_A, BEAT_B}, 16'h0100, 16'h0001);
        send(0, {BEAT_B, BEAT_B}, 16'h0200, 16'h0001);
        chk("lit_b2b_ready_low", 0, 256'(in_ready_a), 256'(0));
        send(0, {BEAT_A, BEAT_A}, 16'h0300, 16'h0001);
        idle(0);
        repeat (8) cyc();
        chk("lit_b2b_count", 0, 256'(done_count_a), 256'(4));

        // Back-pressure during beat 0
        drv_wr_ready[0] = 1'b0;
        send(0, {BEAT_B, BEAT_A}, 16'h0400, 16'h0002);
        idle(0);
        for (int n = 0; n < 5; n++) begin
            chk("lit_bp_addr", 0, 256'(wr_addr_a), 256'(16'h0400));
            chk("lit_bp_data", 0, 256'(wr_data_a), 256'(BEAT_A));
            cyc();
        end
        drv_wr_ready[0] = 1'b1;
        repeat (4) cyc();
        chk("lit_bp_count", 0, 256'(done_count_a), 256'(5));

        // 4 x 32-bit beats, wrapping address, then stride 0
        qb = {128'b0, beat_b[3], beat_b[2], beat_b[1], beat_b[0]};
        send(1, qb, 16'hFFFE, 16'd3);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            chk("lit_wrap_addr", 1, 256'(wr_addr_b), 256'(exp_addr_b[k]));
            chk("lit_wrap_data", 1, 256'(wr_data_b), 256'(beat_b[k]));
            cyc();
        end
        send(1, qb, 16'h1234, 16'd0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            chk("lit_stride0_addr", 1, 256'(wr_addr_b), 256'(16'h1234));
            cyc();
        end
        repeat (3) cyc();

        // Reset during beat 1 with the pending slot full
        send(0, {BEAT_A, BEAT_B}, 16'h0500, 16'h0001);
        send(0, {BEAT_B, BEAT_A}, 16'h0600, 16'h0001);
        idle(0);
        chk("lit_rst_pend_full", 0, 256'(in_ready_a), 256'(0));
        RESETn = 1'b0;
        #1;
        chk("lit_mid_rst_en",    0, 256'(wr_en_a),      256'(0));
        chk("lit_mid_rst_ready", 0, 256'(in_ready_a),   256'(1));
        chk("lit_mid_rst_count", 0, 256'(done_count_a), 256'(0));
        chk("lit_mid_rst_addr",  0, 256'(wr_addr_a),    256'(0));
        chk("lit_mid_rst_data",  0, 256'(wr_data_a),    256'(0));
        cyc();
        cyc();
        RESETn = 1'b1;
        cyc();
        send(0, {BEAT_B, BEAT_A}, 16'h0700, 16'h0001);
        idle(0);
        repeat (4) cyc();
        chk("lit_post_rst_count", 0, 256'(done_count_a), 256'(1));

        // done_count wrap with a 2-bit counter (instance 1 was reset above)
        for (int r = 0; r < 5; r++) begin
            send(1, qb, 16'(16'h0040 * r), 16'd1);
            idle(1);
            repeat (5) cyc();
            chk("lit_cnt_wrap", 1, 256'(done_count_b), 256'(wrap_seq[r]));
        end

        // Randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                drv_valid[i]    = ($urandom_range(0, 3) != 0);
                drv_q[i]        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                drv_base[i]     = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
                drv_stride[i]   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 9));
                drv_wr_ready[i] = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            drv_valid[i] = 1'b0;
            drv_wr_ready[i] = 1'b1;
        end
        repeat (20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
